dm_load_store_unit: RTL and testbench

//  Sits between the EX-stage ALU and the 8 x 64-bit data memory (DM). Takes one
//  RV64 load/store request at a time; checks alignment; performs read-modify-write
//  for sub-doubleword stores; sign/zero-extends load data. Valid/ready handshake
//  on both request and response sides; DM is driven through its clock/w/addr/din/dout ports.

---
 rtl/dm_load_store_unit.sv | 153 +++++++++++++++
 tb/tb_dm_load_store_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_load_store_unit.sv
// Load/store unit between the EX-stage ALU and an 8 x 64-bit synchronous-read data memory.
// One request at a time: alignment check, read-modify-write for narrow stores, load extension.
module dm_load_store_unit #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_w,
    output logic [2:0]        mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StResp} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          f3_q, f3_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                req_misaligned;
    logic                req_illegal;
    logic [5:0]          shamt;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   load_ext;
    logic [DATA_W-1:0]   size_mask;
    logic [DATA_W-1:0]   lane_mask;
    logic [DATA_W-1:0]   merged;

    always_comb begin
        unique case (req_funct3[1:0])
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = |req_addr[1:0];
            2'd3:    req_misaligned = |req_addr[2:0];
            default: req_misaligned = 1'b0;
        endcase
        req_illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    end

    // Lane extraction and lane merge both work on the doubleword shifted by the byte offset.
    always_comb begin
        shamt   = {addr_q[2:0], 3'b000};
        shifted = mem_dout >> shamt;
        case (f3_q)
            3'b000:  load_ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            3'b110:  load_ext = {{(DATA_W-32){1'b0}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
        unique case (f3_q[1:0])
            2'd0:    size_mask = {{(DATA_W-8){1'b0}}, {8{1'b1}}};
            2'd1:    size_mask = {{(DATA_W-16){1'b0}}, {16{1'b1}}};
            2'd2:    size_mask = {{(DATA_W-32){1'b0}}, {32{1'b1}}};
            default: size_mask = {DATA_W{1'b1}};
        endcase
        lane_mask = size_mask << shamt;
        merged    = (mem_dout & ~lane_mask) | ((din_q << shamt) & lane_mask);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    f3_d    = req_funct3;
                    we_d    = req_we;
                    rdata_d = '0;
                    err_d   = req_misaligned | req_illegal;
                    if (req_we) begin
                        din_d = req_wdata;
                    end
                    if (req_misaligned | req_illegal) begin
                        state_d = StResp;
                    end else if (req_we && (req_funct3[1:0] == 2'd3)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:  state_d = StCap;
            StCap: begin
                if (we_q) begin
                    din_d   = merged;
                    state_d = StWr;
                end else begin
                    rdata_d = load_ext;
                    state_d = StResp;
                end
            end
            StWr:  state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_w     = (state_q == StWr);
    assign mem_addr  = addr_q[5:3];
    assign mem_din   = din_q;

endmodule

// File: tb/tb_dm_load_store_unit.sv
// Bench for dm_load_store_unit: directed vector table, reset/backpressure sequences and
// randomized requests checked against a byte-addressed memory model.
module tb_dm_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [5:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_w;
    logic [2:0]  mem_addr;
    logic [63:0] mem_din;
    logic [63:0] mem_dout;

    int passed = 0;
    int total  = 0;
    int wcount = 0;
    logic dm_clear;

    logic [63:0] dm [8];
    logic [7:0]  rb [64];

    always #5 clock = ~clock;

    dm_load_store_unit #(.ADDR_W(6), .DATA_W(64)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_w      (mem_w),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // Synchronous-read data memory.
    always @(posedge clock) begin
        if (dm_clear) begin
            for (int i = 0; i < 8; i++) dm[i] <= '0;
            mem_dout <= '0;
        end else begin
            if (mem_w) dm[mem_addr] <= mem_din;
            mem_dout <= dm[mem_addr];
        end
    end

    always @(negedge clock) if (mem_w) wcount++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else passed++;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [5:0] a);
        if (we ? f3[2] : (f3 == 3'b111)) return 1'b1;
        return (int'(a) % size_of(f3)) != 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [5:0] a);
        logic [63:0] v = '0;
        int sz = size_of(f3);
        for (int i = 0; i < sz; i++) v = v | (64'(rb[int'(a) + i]) << (8 * i));
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ({64{1'b1}} << (8 * sz));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [5:0] a, input logic [63:0] d);
        for (int i = 0; i < size_of(f3); i++) rb[int'(a) + i] = d[8*i +: 8];
    endtask

    task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                          input logic [5:0] a, input logic [63:0] wd, input logic [63:0] exp_rd,
                          input logic exp_err, input int exp_lat, input int hold);
        int lat = 0;
        int wc0;
        logic [63:0] rd0;
        @(negedge clock);
        chk({name, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        wc0 = wcount;
        @(posedge clock);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clock);
            lat++;
        end while (!rsp_valid && lat < 20);
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " rdata"}, rsp_rdata, exp_rd);
        chk({name, " err"}, 64'(rsp_err), 64'(exp_err));
        chk({name, " writes"}, 64'(wcount - wc0), (we && !exp_err) ? 64'd1 : 64'd0);
        rd0 = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk({name, " hold"}, {rsp_valid, req_ready, rsp_rdata == rd0}, {1'b1, 1'b0, 1'b1});
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [5:0]  addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset_n = 1'b0;
        dm_clear = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = '0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 64; i++) rb[i] = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset outputs", {req_ready, rsp_valid, rsp_err, mem_w, 5'(mem_addr)},
            {1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
        chk("reset rdata", rsp_rdata, 64'd0);
        chk("reset din", mem_din, 64'd0);
        reset_n = 1'b1;
        dm_clear = 1'b0;

        vecs.push_back('{"SD 20",   1, 3'd3, 6'h20, 64'h1234_5678, 64'h0, 0, 2});
        vecs.push_back('{"LD 20",   0, 3'd3, 6'h20, 64'h0, 64'h1234_5678, 0, 3});
        vecs.push_back('{"SD 08",   1, 3'd3, 6'h08, 64'hEFEE, 64'h0, 0, 2});
        vecs.push_back('{"SB 09",   1, 3'd0, 6'h09, 64'hAB, 64'h0, 0, 4});
        vecs.push_back('{"LB 09",   0, 3'd0, 6'h09, 64'h0, 64'hFFFF_FFFF_FFFF_FFAB, 0, 3});
        vecs.push_back('{"LBU 09",  0, 3'd4, 6'h09, 64'h0, 64'hAB, 0, 3});
        vecs.push_back('{"LD 08",   0, 3'd3, 6'h08, 64'h0, 64'hABEE, 0, 3});
        vecs.push_back('{"LH 22",   0, 3'd1, 6'h22, 64'h0, 64'h1234, 0, 3});
        vecs.push_back('{"LW 24",   0, 3'd2, 6'h24, 64'h0, 64'h0, 0, 3});
        vecs.push_back('{"LH 03",   0, 3'd1, 6'h03, 64'h0, 64'h0, 1, 1});
        vecs.push_back('{"SW 06",   1, 3'd2, 6'h06, 64'h55, 64'h0, 1, 1});
        vecs.push_back('{"S f3=4",  1, 3'd4, 6'h10, 64'h55, 64'h0, 1, 1});
        vecs.push_back('{"L f3=7",  0, 3'd7, 6'h00, 64'h0, 64'h0, 1, 1});
        vecs.push_back('{"SW 28",   1, 3'd2, 6'h28, 64'hFFFF_FFFF_8000_0001, 64'h0, 0, 4});
        vecs.push_back('{"LW 28",   0, 3'd2, 6'h28, 64'h0, 64'hFFFF_FFFF_8000_0001, 0, 3});
        vecs.push_back('{"LWU 28",  0, 3'd6, 6'h28, 64'h0, 64'h8000_0001, 0, 3});
        vecs.push_back('{"LH 2A",   0, 3'd1, 6'h2A, 64'h0, 64'hFFFF_FFFF_FFFF_8000, 0, 3});
        vecs.push_back('{"LHU 2A",  0, 3'd5, 6'h2A, 64'h0, 64'h8000, 0, 3});
        vecs.push_back('{"LD 28",   0, 3'd3, 6'h28, 64'h0, 64'h8000_0001, 0, 3});

        foreach (vecs[i]) begin
            do_req(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                   vecs[i].rdata, vecs[i].err, vecs[i].lat, 0);
            if (vecs[i].we && !vecs[i].err) ref_store(vecs[i].f3, vecs[i].addr, vecs[i].wdata);
        end

        // Backpressure: response must hold for 5 cycles.
        do_req("LD hold", 1'b0, 3'd3, 6'h20, 64'h0, 64'h1234_5678, 1'b0, 3, 5);

        // Reset during CAP of a byte store: aborted, memory untouched.
        begin
            int wc0;
            @(negedge clock);
            req_valid = 1'b1;
            req_we = 1'b1;
            req_funct3 = 3'd0;
            req_addr = 6'h09;
            req_wdata = 64'h55;
            wc0 = wcount;
            @(posedge clock);
            #1 req_valid = 1'b0;
            @(negedge clock);
            @(negedge clock);
            reset_n = 1'b0;
            @(negedge clock);
            chk("abort outputs", {req_ready, rsp_valid, rsp_err, mem_w, 5'(mem_addr)},
                {1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
            chk("abort rdata/din", rsp_rdata | mem_din, 64'd0);
            reset_n = 1'b1;
            repeat (3) @(negedge clock);
            chk("abort writes", 64'(wcount - wc0), 64'd0);
            do_req("LD 08 post-abort", 1'b0, 3'd3, 6'h08, 64'h0, 64'hABEE, 1'b0, 3, 0);
        end

        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [5:0]  a;
            logic [63:0] wd;
            logic        e;
            int          lat;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ~6'(size_of(f3) - 1);
            wd = {$urandom, $urandom};
            e  = ref_err(we, f3, a);
            if (e) lat = 1;
            else if (!we) lat = 3;
            else if (f3[1:0] == 2'd3) lat = 2;
            else lat = 4;
            do_req("rand", we, f3, a, wd, (e || we) ? 64'h0 : ref_load(f3, a), e, lat,
                   $urandom_range(0, 2));
            if (we && !e) ref_store(f3, a, wd);
        end

        @(negedge clock);
        for (int w = 0; w < 8; w++) begin
            logic [63:0] exp;
            for (int b = 0; b < 8; b++) exp[8*b +: 8] = rb[8*w + b];
            chk("final dm word", dm[w], exp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
